// File: rtl/sonic_vc_demultiplexer_adapter.sv
// rtl/sonic_vc_demultiplexer_adapter.sv - Avalon-ST ready-latency adapter (readyLatency LATENCY -> 0) with FWFT FIFO
module sonic_vc_demultiplexer_adapter #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 8
) (
    input  logic         clk,
    input  logic         reset,
    output logic         in_ready,
    input  logic         in_valid,
    input  logic [127:0] in_data,
    input  logic         in_channel,
    input  logic         in_error,
    input  logic         in_startofpacket,
    input  logic         in_endofpacket,
    input  logic         in_empty,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [127:0] out_data,
    output logic         out_channel,
    output logic         out_error,
    output logic         out_startofpacket,
    output logic         out_endofpacket,
    output logic         out_empty,
    output logic         overflow_err,
    output logic         protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 133;
    localparam int WW = $clog2(LATENCY + 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   THRESH = (AW + 1)'(DEPTH - LATENCY - 1);
    localparam logic [WW-1:0] WARM   = WW'(LATENCY);

    logic [PW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [LATENCY-1:0] ready_hist;
    logic [WW-1:0]      warm;
    logic [PW-1:0]      in_payload;
    logic               push;
    logic               pop;
    logic               full;
    logic               hist_ok;

    assign in_payload = {in_data, in_channel, in_error, in_startofpacket, in_endofpacket, in_empty};
    assign {out_data, out_channel, out_error, out_startofpacket, out_endofpacket, out_empty} = mem[rd_ptr];

    // Threshold leaves room for the LATENCY+1 beats that may still land after in_ready is seen high.
    assign in_ready  = (count <= THRESH);
    assign out_valid = (count != '0);
    assign full      = (count == FULL);
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    // Until LATENCY cycles have passed since reset the history is not yet meaningful; treat it as ready.
    assign hist_ok   = (warm < WARM) ? 1'b1 : ready_hist[LATENCY-1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ready_hist   <= '0;
            warm         <= '0;
            overflow_err <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            ready_hist[0] <= in_ready;
            for (int i = 1; i < LATENCY; i++) begin
                ready_hist[i] <= ready_hist[i-1];
            end
            if (warm != WARM) begin
                warm <= warm + 1'b1;
            end
            if (in_valid && full) begin
                overflow_err <= 1'b1;
            end
            if (in_valid && !hist_ok) begin
                protocol_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sonic_vc_demultiplexer_adapter.sv
// tb/tb_sonic_vc_demultiplexer_adapter.sv - scoreboard bench for sonic_vc_demultiplexer_adapter
module tb_sonic_vc_demultiplexer_adapter;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 8;

    logic         clk;
    logic         reset;
    logic         in_ready;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_channel;
    logic         in_error;
    logic         in_startofpacket;
    logic         in_endofpacket;
    logic         in_empty;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         out_channel;
    logic         out_error;
    logic         out_startofpacket;
    logic         out_endofpacket;
    logic         out_empty;
    logic         overflow_err;
    logic         protocol_err;

    logic [132:0] in_pl;
    logic [132:0] out_pl;
    assign {in_data, in_channel, in_error, in_startofpacket, in_endofpacket, in_empty} = in_pl;
    assign out_pl = {out_data, out_channel, out_error, out_startofpacket, out_endofpacket, out_empty};

    sonic_vc_demultiplexer_adapter #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_channel(out_channel), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_empty(out_empty), .overflow_err(overflow_err), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [132:0] exp_q[$];
    bit           s_hist[$];

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [132:0] rand_pl();
        logic [4:0] lo;
        lo = 5'($urandom);
        return {$urandom, $urandom, $urandom, $urandom, lo};
    endfunction

    // Compliant source: a beat may go only if in_ready was high LATENCY cycles earlier.
    task automatic cyc(input bit want, input logic [132:0] pl, input bit force_send, output bit sent);
        bit ok;
        s_hist.push_back(in_ready);
        ok = (s_hist.size() <= LATENCY) ? 1'b1 : s_hist[s_hist.size() - 1 - LATENCY];
        sent = want && (ok || force_send);
        in_valid = sent;
        in_pl = pl;
        if (sent && ok) exp_q.push_back(pl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit s;
        repeat (n) cyc(1'b0, rand_pl(), 1'b0, s);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        s_hist.delete();
    endtask

    // Reference model: occupancy, expected flags and in_ready history, computed from the rules.
    int  m_count = 0;
    int  m_k = 0;
    bit  m_rh[$];
    bit  m_ovf = 0;
    bit  m_prot = 0;
    bit  m_live = 0;
    bit  prev_stall = 0;
    logic [132:0] prev_pl;

    always @(negedge clk) begin
        bit exp_ready;
        bit hist_ok;
        bit m_push;
        bit m_pop;
        if (reset) begin
            m_count = 0; m_k = 0; m_rh.delete();
            m_ovf = 0; m_prot = 0; prev_stall = 0; m_live = 1;
        end else if (m_live) begin
            exp_ready = (m_count <= DEPTH - LATENCY - 1);
            check("out_valid", out_valid, m_count != 0);
            check("in_ready", in_ready, exp_ready);
            check("overflow_err", overflow_err, m_ovf);
            check("protocol_err", protocol_err, m_prot);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_payload", out_pl, prev_pl);
            end
            m_pop = (m_count != 0) && out_ready;
            if (m_pop) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL pop_unexpected actual=%h required=none", out_pl);
                end else begin
                    check("pop_data", out_pl, exp_q.pop_front());
                end
            end
            m_rh.push_back(exp_ready);
            hist_ok = (m_k < LATENCY) ? 1'b1 : m_rh[m_k - LATENCY];
            if (in_valid) begin
                if (m_count == DEPTH) m_ovf = 1;
                if (!hist_ok) m_prot = 1;
            end
            m_push = in_valid && (m_count < DEPTH);
            m_count = m_count + int'(m_push) - int'(m_pop);
            m_k++;
            prev_stall = (m_count_prev_valid(m_count, m_push, m_pop)) && !out_ready;
            prev_pl = out_pl;
        end
    end

    function automatic bit m_count_prev_valid(input int c_after, input bit pu, input bit po);
        return (c_after - int'(pu) + int'(po)) != 0;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        bit           sent;
        int           accepted;
        int           tries;
        int           n_sent;
        int           budget;
        logic [132:0] pl;
        logic [127:0] d;
        reset = 1'b1;
        in_valid = 1'b0;
        in_pl = '0;
        out_ready = 1'b0;
        do_reset(3);

        // T1: 16 sequential beats, full rate
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 128'(i);
            pl = {d, 1'b0, 1'b0, i == 0, i == 15, 1'b0};
            sent = 0; tries = 0;
            while (!sent && tries < 50) begin
                cyc(1'b1, pl, 1'b0, sent);
                tries++;
            end
        end
        idle(4);
        check("t1_drained", 133'(exp_q.size()), 133'(0));

        // T2: backpressure, compliant back-to-back source
        out_ready = 1'b0;
        accepted = 0;
        repeat (20) begin
            cyc(1'b1, rand_pl(), 1'b0, sent);
            accepted += int'(sent);
        end
        check("t2_accepted", 133'(accepted), 133'(8));
        check("t2_in_ready", in_ready, 1'b0);
        check("t2_overflow", overflow_err, 1'b0);

        // T3: drain
        out_ready = 1'b1;
        idle(12);
        check("t3_drained", 133'(exp_q.size()), 133'(0));
        check("t3_out_valid", out_valid, 1'b0);

        // T4: full FIFO, one non-compliant beat
        out_ready = 1'b0;
        repeat (12) cyc(1'b1, rand_pl(), 1'b0, sent);
        cyc(1'b1, rand_pl(), 1'b1, sent);
        idle(2);
        check("t4_overflow", overflow_err, 1'b1);
        check("t4_protocol", protocol_err, 1'b1);
        check("t4_full_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        idle(12);
        check("t4_drained", 133'(exp_q.size()), 133'(0));
        check("t4_overflow_sticky", overflow_err, 1'b1);

        // T5: random traffic
        do_reset(2);
        n_sent = 0; budget = 0;
        while (n_sent < 10000 && budget < 60000) begin
            out_ready = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 3) != 0, rand_pl(), 1'b0, sent);
            n_sent += int'(sent);
            budget++;
        end
        check("t5_sent", 133'(n_sent), 133'(10000));
        out_ready = 1'b1;
        idle(20);
        check("t5_drained", 133'(exp_q.size()), 133'(0));
        check("t5_overflow", overflow_err, 1'b0);
        check("t5_protocol", protocol_err, 1'b0);

        // T6: reset with 5 beats stored
        out_ready = 1'b0;
        n_sent = 0; tries = 0;
        while (n_sent < 5 && tries < 50) begin
            cyc(1'b1, rand_pl(), 1'b0, sent);
            n_sent += int'(sent);
            tries++;
        end
        idle(1);
        check("t6_in_ready_c5", in_ready, 1'b1);
        check("t6_valid_c5", out_valid, 1'b1);
        do_reset(1);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_flags", {overflow_err, protocol_err}, 2'b00);
        pl = rand_pl();
        cyc(1'b1, pl, 1'b0, sent);
        check("t6_valid_one", out_valid, 1'b1);
        check("t6_payload", out_pl, pl);
        out_ready = 1'b1;
        idle(2);
        check("t6_alone", out_valid, 1'b0);
        check("t6_drained", 133'(exp_q.size()), 133'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
